// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external RAM bus arbiter.
// Build option: MEMARB_RR_EN selects round-robin arbitration on contention;
// without it the data port always wins over instruction fetch.
package mem_arb_pkg;

    // Width of the wait-state down-counter; WAIT_STATES must fit in it.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    // Counter load value for an access; the strobe stays low for this many
    // extra cycles beyond the first.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int unsigned ws);
        return ws[WAIT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the fetch port and the data port.
// Build option: MEMARB_RR_EN turns on round-robin on contention using the
// last granted port; otherwise data has fixed priority over fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
`ifdef MEMARB_RR_EN
    input  grant_e last_grant,
`endif
    output grant_e grant,
    output logic   valid
);

    // Pick the winner among the active requests.
    always_comb begin
        valid = if_req | d_req;
`ifdef MEMARB_RR_EN
        if (if_req && d_req) begin
            grant = (last_grant == GNT_D) ? GNT_IF : GNT_D;
        end else if (d_req) begin
            grant = GNT_D;
        end else begin
            grant = GNT_IF;
        end
`else
        // Data is the older instruction in the pipeline; serving it first
        // prevents the memory stage from blocking the fetch it depends on.
        grant = d_req ? GNT_D : GNT_IF;
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external RAM bus between instruction fetch and the data port.
// Each access: IDLE (arbitrate, latch) -> ACCESS (strobe low for
// WAIT_STATES+1 cycles) -> RECOVER (strobes high, Ready pulse) -> IDLE.
// Build option: MEMARB_RR_EN enables round-robin arbitration and the
// last-grant register; by default data has fixed priority.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | bus quiet; requests sampled, winner's address/data latched
//   ACCESS  | strobe low; counter runs down, read data captured at zero
//   RECOVER | strobes high, write data still driven; Ready to the winner
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [DATA_W-1:0] IfRdata,
    output logic              IfReady,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic [DATA_W-1:0] DRdata,
    output logic              DReady,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWdata,
    output logic              RamDataOe,
    input  logic [DATA_W-1:0] RamRdata,
    output logic              ReadRAM_n,
    output logic              WriteRAM_n
);

    localparam logic [WAIT_CNT_W-1:0] WS_LOAD = wait_load(WAIT_STATES);

    state_e                state_q,     state_d;
    logic [WAIT_CNT_W-1:0] cnt_q,       cnt_d;
    grant_e                gnt_q,       gnt_d;
    logic                  we_q,        we_d;
    logic [ADDR_W-1:0]     ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
    logic                  rd_n_q,      rd_n_d;
    logic                  wr_n_q,      wr_n_d;
    logic                  oe_q,        oe_d;
    logic                  if_ready_q,  if_ready_d;
    logic                  d_ready_q,   d_ready_d;
    logic [DATA_W-1:0]     if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q,   d_rdata_d;
`ifdef MEMARB_RR_EN
    grant_e                last_gnt_q,  last_gnt_d;
`endif

    grant_e pick_gnt;
    logic   pick_valid;

    mem_arb_pick u_pick (
        .if_req     (IfReq),
        .d_req      (DReq),
`ifdef MEMARB_RR_EN
        .last_grant (last_gnt_q),
`endif
        .grant      (pick_gnt),
        .valid      (pick_valid)
    );

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        oe_d        = oe_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEMARB_RR_EN
        last_gnt_d  = last_gnt_q;
`endif

        case (state_q)
            IDLE: begin
                rd_n_d = 1'b1;
                wr_n_d = 1'b1;
                oe_d   = 1'b0;
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    cnt_d   = WS_LOAD;
                    state_d = ACCESS;
`ifdef MEMARB_RR_EN
                    last_gnt_d = pick_gnt;
`endif
                    if (pick_gnt == GNT_D) begin
                        we_d        = DWe;
                        ram_addr_d  = DAddr;
                        ram_wdata_d = DWdata;
                    end else begin
                        we_d        = 1'b0;
                        ram_addr_d  = IfAddr;
                    end
                    // Strobes are registered so they leave the flop cleanly
                    // on the edge that enters ACCESS.
                    if ((pick_gnt == GNT_D) && DWe) begin
                        wr_n_d = 1'b0;
                        oe_d   = 1'b1;
                    end else begin
                        rd_n_d = 1'b0;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    // Output enable is left as is so write data is held
                    // through the strobe's rising edge.
                    if (!we_q) begin
                        if (gnt_q == GNT_D) begin
                            d_rdata_d = RamRdata;
                        end else begin
                            if_rdata_d = RamRdata;
                        end
                    end
                    if (gnt_q == GNT_D) begin
                        d_ready_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RECOVER: begin
                state_d = IDLE;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                oe_d    = 1'b0;
            end

            default: begin
                state_d = IDLE;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Register all sequencer state and bus outputs; reset aborts any access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= GNT_D;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEMARB_RR_EN
            last_gnt_q  <= GNT_D;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            oe_q        <= oe_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEMARB_RR_EN
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    assign IfRdata    = if_rdata_q;
    assign IfReady    = if_ready_q;
    assign DRdata     = d_rdata_q;
    assign DReady     = d_ready_q;
    assign RamAddr    = ram_addr_q;
    assign RamWdata   = ram_wdata_q;
    assign RamDataOe  = oe_q;
    assign ReadRAM_n  = rd_n_q;
    assign WriteRAM_n = wr_n_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a WAIT_STATES=1 instance with a small RAM
// model, plus a WAIT_STATES=0 instance for the zero-wait read case.
module tb_mem_bus_arbiter;

    localparam int WS  = 1;
    localparam int LAT = WS + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, d_ready, ram_oe, rd_n, wr_n;

    logic        if_req0 = 1'b0, d_req0 = 1'b0;
    logic [31:0] ram_rdata0 = '0;
    logic [31:0] if_rdata0, d_rdata0, ram_addr0, ram_wdata0;
    logic        if_ready0, d_ready0, ram_oe0, rd_n0, wr_n0;

    int checks = 0;
    int errors = 0;

    // RAM model contents and the bench's spec-level view of memory.
    logic [31:0] ram [16];
    logic        ram_init = 1'b1;
    logic [31:0] model_mem [16];
    logic [31:0] exp_if_rd = '0, exp_d_rd = '0;
    bit          m_last_d = 1'b1;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .Clk(clk), .Reset(reset),
        .IfReq(if_req), .IfAddr(if_addr), .IfRdata(if_rdata), .IfReady(if_ready),
        .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWdata(d_wdata),
        .DRdata(d_rdata), .DReady(d_ready),
        .RamAddr(ram_addr), .RamWdata(ram_wdata), .RamDataOe(ram_oe),
        .RamRdata(ram_rdata), .ReadRAM_n(rd_n), .WriteRAM_n(wr_n)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(reset),
        .IfReq(if_req0), .IfAddr(if_addr), .IfRdata(if_rdata0), .IfReady(if_ready0),
        .DReq(d_req0), .DWe(d_we), .DAddr(d_addr), .DWdata(d_wdata),
        .DRdata(d_rdata0), .DReady(d_ready0),
        .RamAddr(ram_addr0), .RamWdata(ram_wdata0), .RamDataOe(ram_oe0),
        .RamRdata(ram_rdata0), .ReadRAM_n(rd_n0), .WriteRAM_n(wr_n0)
    );

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= (i == 0) ? 32'hDEADBEEF : 32'hA5A50000 + i;
        end else if (!wr_n) begin
            ram[ram_addr[5:2]] <= ram_wdata;
        end
    end
    assign ram_rdata = ram[ram_addr[5:2]];

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (if_ready && d_ready) begin
                errors++;
                $display("FAIL one_ready: IfReady=%0b DReady=%0b, at most one may be high", if_ready, d_ready);
            end
            checks++;
            if (!rd_n && !wr_n) begin
                errors++;
                $display("FAIL strobe_excl: ReadRAM_n=%0b WriteRAM_n=%0b, both low", rd_n, wr_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_pick_d(input bit rq_if, input bit rq_d);
        bit w;
`ifdef MEMARB_RR_EN
        w = rq_d && (!rq_if || !m_last_d);
        m_last_d = w;
`else
        w = rq_d;
`endif
        return w;
    endfunction

    // One arbitrated access from an idle bus, checked against the model.
    task automatic run_txn(input bit rq_if, input bit rq_d, input bit we,
                           input logic [31:0] a_if, input logic [31:0] a_d,
                           input logic [31:0] wd, input string tag);
        bit win_d, wwe, got, addr_bad, wd_bad;
        logic [31:0] wa;
        int rd_cnt, wr_cnt, oe_cnt, rdy_idx;
        win_d = model_pick_d(rq_if, rq_d);
        wa  = win_d ? a_d : a_if;
        wwe = win_d && we;
        got = 0; addr_bad = 0; wd_bad = 0;
        rd_cnt = 0; wr_cnt = 0; oe_cnt = 0; rdy_idx = -1;
        tick();
        if_req = rq_if; if_addr = a_if;
        d_req = rq_d; d_we = we; d_addr = a_d; d_wdata = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!rd_n) rd_cnt++;
            if (!wr_n) wr_cnt++;
            if (ram_oe) oe_cnt++;
            if ((!rd_n || !wr_n) && ram_addr !== wa) addr_bad = 1;
            if (!wr_n && ram_wdata !== wd) wd_bad = 1;
            if (if_ready || d_ready) begin
                got = 1;
                rdy_idx = i;
                checks++;
                if (d_ready !== win_d || if_ready !== !win_d) begin
                    errors++;
                    $display("FAIL %s grant: IfReady=%0b DReady=%0b, expected winner %s",
                             tag, if_ready, d_ready, win_d ? "D" : "IF");
                end
                if (wwe) model_mem[wa[5:2]] = wd;
                else if (win_d) exp_d_rd = model_mem[wa[5:2]];
                else exp_if_rd = model_mem[wa[5:2]];
                checks++;
                if (if_rdata !== exp_if_rd || d_rdata !== exp_d_rd) begin
                    errors++;
                    $display("FAIL %s rdata: IfRdata=%h DRdata=%h, expected %h %h",
                             tag, if_rdata, d_rdata, exp_if_rd, exp_d_rd);
                end
            end
        end
        checks++;
        if (rdy_idx != LAT) begin
            errors++;
            $display("FAIL %s latency: ready at cycle %0d, expected %0d", tag, rdy_idx, LAT);
        end
        checks++;
        if (rd_cnt != (wwe ? 0 : WS + 1) || wr_cnt != (wwe ? WS + 1 : 0) || oe_cnt != (wwe ? WS + 2 : 0)) begin
            errors++;
            $display("FAIL %s strobes: rd_low=%0d wr_low=%0d oe_high=%0d, expected %0d %0d %0d", tag,
                     rd_cnt, wr_cnt, oe_cnt, wwe ? 0 : WS + 1, wwe ? WS + 1 : 0, wwe ? WS + 2 : 0);
        end
        checks++;
        if (addr_bad || wd_bad) begin
            errors++;
            $display("FAIL %s bus: addr_bad=%0b wdata_bad=%0b, expected addr %h data %h",
                     tag, addr_bad, wd_bad, wa, wd);
        end
        tick();
        if_req = 0; d_req = 0;
        @(negedge clk);
        checks++;
        if (rd_n !== 1'b1 || wr_n !== 1'b1 || ram_oe !== 1'b0 || if_ready || d_ready) begin
            errors++;
            $display("FAIL %s idle_after: rd_n=%0b wr_n=%0b oe=%0b rdy=%0b%0b, expected 1 1 0 00",
                     tag, rd_n, wr_n, ram_oe, if_ready, d_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_n !== 1'b1 || wr_n !== 1'b1 || ram_oe !== 1'b0 || if_ready !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rd_n=%0b wr_n=%0b oe=%0b rdy=%0b%0b, expected 1 1 0 00",
                     rd_n, wr_n, ram_oe, if_ready, d_ready);
        end
        checks++;
        if (ram_addr !== 32'h0 || ram_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h ifrd=%h drd=%h, expected all zero",
                     ram_addr, ram_wdata, if_rdata, d_rdata);
        end
        checks++;
        if (rd_n0 !== 1'b1 || if_ready0 !== 1'b0 || if_rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_ws0: rd_n=%0b rdy=%0b rdata=%h, expected 1 0 0", rd_n0, if_ready0, if_rdata0);
        end
        tick();
        reset = 0; ram_init = 0;
    endtask

    task automatic test_if_read();
        run_txn(1, 0, 0, 32'h100, 32'h0, 32'h0, "if_read");
        checks++;
        if (if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL if_read_value: IfRdata=%h, expected deadbeef", if_rdata);
        end
    endtask

    task automatic test_d_write();
        run_txn(0, 1, 1, 32'h0, 32'h2004, 32'h12345678, "d_write");
    endtask

    task automatic test_wait0();
        logic [31:0] v;
        int rd_cnt, rdy_idx;
        bit got;
        v = $urandom; rd_cnt = 0; rdy_idx = -1; got = 0;
        tick();
        if_req0 = 1; if_addr = 32'h40; ram_rdata0 = v;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!rd_n0) rd_cnt++;
            if (if_ready0) begin got = 1; rdy_idx = i; end
        end
        checks++;
        if (rdy_idx != 2 || rd_cnt != 1) begin
            errors++;
            $display("FAIL ws0_timing: ready at %0d strobe_low=%0d, expected 2 1", rdy_idx, rd_cnt);
        end
        checks++;
        if (if_rdata0 !== v || ram_addr0 !== 32'h40) begin
            errors++;
            $display("FAIL ws0_data: rdata=%h addr=%h, expected %h 00000040", if_rdata0, ram_addr0, v);
        end
        tick();
        if_req0 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n, last_idx;
        bit win_d;
        logic [31:0] a_if, a_d;
        n = 0; last_idx = -1;
        a_if = {$urandom} & 32'hFFFF_FFFC;
        a_d  = {$urandom} & 32'hFFFF_FFFC;
        tick();
        if_req = 1; if_addr = a_if; d_req = 1; d_we = 0; d_addr = a_d;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                win_d = model_pick_d(1, 1);
                if (win_d) exp_d_rd = model_mem[a_d[5:2]];
                else exp_if_rd = model_mem[a_if[5:2]];
                checks++;
                if (d_ready !== win_d || if_rdata !== exp_if_rd || d_rdata !== exp_d_rd) begin
                    errors++;
                    $display("FAIL b2b_grant%0d: DReady=%0b ifrd=%h drd=%h, expected %0b %h %h",
                             n, d_ready, if_rdata, d_rdata, win_d, exp_if_rd, exp_d_rd);
                end
                checks++;
                if (i - last_idx != ((n == 0) ? LAT + 1 : LAT + 1)) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: gap %0d, expected %0d", n, i - last_idx, LAT + 1);
                end
                last_idx = (n == 0) ? i - LAT - 1 + LAT + 1 : i;
                if (n == 0) last_idx = i;
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d ready pulses, expected 4", n);
        end
        tick();
        if_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_mid();
        logic [31:0] a;
        int rdy_cnt, rdy_idx, rd_cnt;
        a = {$urandom} & 32'hFFFF_FFFC;
        rdy_cnt = 0; rdy_idx = -1; rd_cnt = 0;
        void'(model_pick_d(1, 0));
        tick();
        if_req = 1; if_addr = a;
        @(negedge clk);
        tick();
        if_req = 0;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            if (!rd_n) rd_cnt++;
            if (if_ready) begin rdy_cnt++; rdy_idx = i; end
        end
        exp_if_rd = model_mem[a[5:2]];
        checks++;
        if (rdy_cnt != 1 || rdy_idx != LAT || rd_cnt != WS + 1) begin
            errors++;
            $display("FAIL drop_mid: ready_count=%0d at %0d strobe_low=%0d, expected 1 at %0d low %0d",
                     rdy_cnt, rdy_idx, rd_cnt, LAT, WS + 1);
        end
        checks++;
        if (if_rdata !== exp_if_rd) begin
            errors++;
            $display("FAIL drop_mid_data: IfRdata=%h, expected %h", if_rdata, exp_if_rd);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] a, wd;
        int bad;
        a = {$urandom} & 32'hFFFF_FFFC;
        wd = $urandom;
        bad = 0;
        tick();
        d_req = 1; d_we = 1; d_addr = a; d_wdata = wd;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        reset = 1;
        @(negedge clk);
        tick();
        reset = 0; d_req = 0; d_we = 0;
        // The RAM saw the strobe low before the abort, so the location holds wd.
        model_mem[a[5:2]] = wd;
        exp_if_rd = '0; exp_d_rd = '0; m_last_d = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_n !== 1'b1 || ram_oe !== 1'b0 || d_ready !== 1'b0 || rd_n !== 1'b1 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_abort: wr_n=%0b oe=%0b DReady=%0b rd_n=%0b drd=%h, expected 1 0 0 1 0",
                     wr_n, ram_oe, d_ready, rd_n, d_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (d_ready || if_ready || !wr_n || !rd_n) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_quiet: %0d active cycles after abort, expected 0", bad);
        end
    endtask

    task automatic test_random();
        int pat;
        bit rq_if, rq_d, we;
        for (int k = 0; k < 24; k++) begin
            pat = $urandom_range(0, 2);
            rq_if = (pat != 1);
            rq_d  = (pat != 0);
            we    = $urandom_range(0, 1);
            run_txn(rq_if, rq_d, we, {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
                    $urandom, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = (i == 0) ? 32'hDEADBEEF : 32'hA5A50000 + i;
        test_reset();
        test_if_read();
        test_d_write();
        test_wait0();
        test_back_to_back();
        test_drop_mid();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
